dmem_seq: RTL and testbench

Load/store sequencer between the core's 32-bit memory stage and the byte-wide data memory (32 x 8, combinational read, write on clock edge). It accepts one byte, halfword or word request at a time and breaks it into little-endian byte accesses, one per cycle. Loads come back sign- or zero-extended; misaligned or illegal requests are rejected. It is the only master driving the data memory's address, write-enable and write-data pins.

---
 rtl/dmem_seq_if.sv | 27 ++
 rtl/dmem_seq.sv | 131 +++++++++++++
 tb/tb_dmem_seq.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_seq_if.sv
// dmem_seq_if: request/response bus between the core memory stage and dmem_seq.
//   master: drives req_* (core side), receives req_ready and resp_*
//   slave : receives req_*, drives req_ready and resp_* (dmem_seq side)
interface dmem_seq_if #(
  parameter int unsigned ADDR_WIDTH = 5
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [1:0]            req_size;
  logic                  req_signed;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [31:0]           req_wdata;
  logic                  resp_valid;
  logic [31:0]           resp_rdata;
  logic                  resp_error;

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_error
  );

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_error
  );
endinterface

// File: rtl/dmem_seq.sv
// dmem_seq: splits byte/half/word loads and stores into little-endian byte
// accesses to a byte-wide data memory, one byte per cycle.
//   clk, reset   : clock, synchronous active-high reset
//   bus (slave)  : request/response handshake (dmem_seq_if)
//   o_mem_addr   : data memory byte address
//   o_mem_we     : data memory write enable (forced low while reset is high)
//   o_mem_wdata  : data memory write byte
//   i_mem_rdata  : data memory read byte (combinational on o_mem_addr)
module dmem_seq #(
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  dmem_seq_if.slave             bus,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic                  o_mem_we,
  output logic [7:0]            o_mem_wdata,
  input  logic [7:0]            i_mem_rdata
);

  localparam int unsigned CNT_W = 2;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_write;
  logic                  r_signed;
  logic                  r_err;
  logic [1:0]            r_size;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_wdata;
  logic [31:0]           r_buf;
  logic [CNT_W-1:0]      r_cnt;

  logic                  w_accept;
  logic                  w_req_err;
  logic [CNT_W-1:0]      w_last_idx;

  // Request decode: size 11 is illegal; half/word must be naturally aligned.
  always_comb begin
    w_accept  = bus.req_valid && (r_state == S_IDLE);
    w_req_err = (bus.req_size == 2'b11) ||
                ((bus.req_size == 2'b01) && bus.req_addr[0]) ||
                ((bus.req_size == 2'b10) && (bus.req_addr[1:0] != 2'b00));
    case (r_size)
      2'b00:   w_last_idx = CNT_W'(0);
      2'b01:   w_last_idx = CNT_W'(1);
      default: w_last_idx = CNT_W'(3);
    endcase
  end

  // Next state and outputs.
  always_comb begin
    w_state_nxt    = r_state;
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    bus.resp_rdata = 32'h0;
    bus.resp_error = 1'b0;
    o_mem_addr     = '0;
    o_mem_we       = 1'b0;
    o_mem_wdata    = 8'h0;
    case (r_state)
      S_IDLE: begin
        bus.req_ready = 1'b1;
        if (w_accept) w_state_nxt = w_req_err ? S_RESP : S_ACCESS;
      end
      S_ACCESS: begin
        o_mem_addr = r_addr + ADDR_WIDTH'(r_cnt);
        // Gated by reset so an aborted store never writes on the reset edge.
        o_mem_we   = r_write & ~reset;
        if (r_write) o_mem_wdata = r_wdata[{r_cnt, 3'b000} +: 8];
        if (r_cnt == w_last_idx) w_state_nxt = S_RESP;
      end
      S_RESP: begin
        bus.resp_valid = 1'b1;
        bus.resp_error = r_err;
        if (!r_write && !r_err) begin
          case (r_size)
            2'b00:   bus.resp_rdata = {{24{r_signed & r_buf[7]}},  r_buf[7:0]};
            2'b01:   bus.resp_rdata = {{16{r_signed & r_buf[15]}}, r_buf[15:0]};
            default: bus.resp_rdata = r_buf;
          endcase
        end
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register, request latch, byte counter and load buffer.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_write  <= 1'b0;
      r_signed <= 1'b0;
      r_err    <= 1'b0;
      r_size   <= 2'b00;
      r_addr   <= '0;
      r_wdata  <= 32'h0;
      r_buf    <= 32'h0;
      r_cnt    <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_write  <= bus.req_write;
            r_size   <= bus.req_size;
            r_signed <= bus.req_signed;
            r_addr   <= bus.req_addr;
            r_wdata  <= bus.req_wdata;
            r_err    <= w_req_err;
            r_cnt    <= '0;
            r_buf    <= 32'h0;
          end
        end
        S_ACCESS: begin
          if (!r_write) r_buf[{r_cnt, 3'b000} +: 8] <= i_mem_rdata;
          r_cnt <= r_cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_seq.sv
// tb_dmem_seq: self-checking bench for dmem_seq with a byte memory model and
// a request-level reference model of memory contents and load results.
module tb_dmem_seq;

  logic       clk;
  logic       reset;
  logic [4:0] mem_addr;
  logic       mem_we;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic [7:0] mem [32];
  logic [7:0] ref_mem [32];
  logic [4:0] we_a [$];
  logic [7:0] we_d [$];
  int n_tests;
  int n_fail;

  dmem_seq_if #(.ADDR_WIDTH(5)) bus ();

  dmem_seq #(.ADDR_WIDTH(5)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .o_mem_addr  (mem_addr),
    .o_mem_we    (mem_we),
    .o_mem_wdata (mem_wdata),
    .i_mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

  // Request-level reference: memory as a byte array, loads assembled with arithmetic.
  task automatic ref_op(input logic w, input logic [1:0] sz, input logic sg,
                        input logic [4:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er);
    int n;
    longint v;
    n  = 1 << sz;
    er = (sz == 2'b11) || ((int'(a) % n) != 0);
    rd = 32'h0;
    if (!er) begin
      if (w) begin
        for (int i = 0; i < n; i++) ref_mem[int'(a) + i] = 8'((wd >> (8 * i)) & 32'hFF);
      end else begin
        v = 0;
        for (int i = 0; i < n; i++) v = v + (longint'(ref_mem[int'(a) + i]) << (8 * i));
        if (sg && v[8 * n - 1]) v = v - (longint'(1) << (8 * n));
        rd = v[31:0];
      end
    end
  endtask

  // Drive one request, return response and latency (cycles after the accept cycle).
  task automatic do_req(input logic w, input logic [1:0] sz, input logic sg,
                        input logic [4:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int lat);
    int guard;
    we_a.delete();
    we_d.delete();
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = w; bus.req_size = sz;
    bus.req_signed = sg; bus.req_addr = a; bus.req_wdata = wd;
    guard = 0;
    while (!bus.req_ready && guard < 20) begin @(negedge clk); guard++; end
    if (!bus.req_ready) begin
      n_tests++; n_fail++;
      $display("FAIL accept_timeout: req_ready stayed %b, required 1", bus.req_ready);
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.resp_valid && lat < 20) begin
      if (mem_we) begin we_a.push_back(mem_addr); we_d.push_back(mem_wdata); end
      @(negedge clk);
      lat++;
    end
    if (!bus.resp_valid) begin
      n_tests++; n_fail++;
      $display("FAIL resp_timeout: resp_valid stayed %b, required 1", bus.resp_valid);
    end
    rd = bus.resp_rdata;
    er = bus.resp_error;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_size = 2'b10;
    bus.req_signed = 1'b0; bus.req_addr = 5'd0; bus.req_wdata = 32'h0;
    repeat (3) @(negedge clk);
    n_tests++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b want 1", bus.req_ready); end
    n_tests++; if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_resp_valid: got %b want 0", bus.resp_valid); end
    n_tests++; if (bus.resp_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_rdata: got %h want 0", bus.resp_rdata); end
    n_tests++; if (bus.resp_error !== 1'b0) begin n_fail++; $display("FAIL rst_error: got %b want 0", bus.resp_error); end
    n_tests++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL rst_we: got %b want 0", mem_we); end
    n_tests++; if (mem_addr !== 5'd0) begin n_fail++; $display("FAIL rst_addr: got %h want 0", mem_addr); end
    n_tests++; if (mem_wdata !== 8'h0) begin n_fail++; $display("FAIL rst_wdata: got %h want 0", mem_wdata); end
    bus.req_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    n_tests++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_ready: got %b want 1", bus.req_ready); end
  endtask

  task automatic test_word_store_load();
    logic [31:0] rd, erd;
    logic er, eer;
    int lat;
    logic [7:0] exp_b [4];
    exp_b = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    do_req(1'b1, 2'b10, 1'b0, 5'd4, 32'hDEADBEEF, rd, er, lat);
    ref_op(1'b1, 2'b10, 1'b0, 5'd4, 32'hDEADBEEF, erd, eer);
    n_tests++; if (lat != 5) begin n_fail++; $display("FAIL wst_latency: got %0d want 5", lat); end
    n_tests++; if (rd !== 32'h0 || er !== 1'b0) begin n_fail++; $display("FAIL wst_resp: got %h/%b want 0/0", rd, er); end
    n_tests++; if (we_a.size() != 4) begin n_fail++; $display("FAIL wst_we_cycles: got %0d want 4", we_a.size()); end
    if (we_a.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        n_tests++;
        if (we_a[i] !== 5'(4 + i) || we_d[i] !== exp_b[i]) begin
          n_fail++; $display("FAIL wst_byte%0d: got %0d/%h want %0d/%h", i, we_a[i], we_d[i], 4 + i, exp_b[i]);
        end
      end
    end
    do_req(1'b0, 2'b10, 1'b0, 5'd4, $urandom, rd, er, lat);
    ref_op(1'b0, 2'b10, 1'b0, 5'd4, 32'h0, erd, eer);
    n_tests++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin n_fail++; $display("FAIL wld_data: got %h/%b want deadbeef/0", rd, er); end
    n_tests++; if (rd !== erd) begin n_fail++; $display("FAIL wld_model: got %h want %h", rd, erd); end
    n_tests++; if (lat != 5) begin n_fail++; $display("FAIL wld_latency: got %0d want 5", lat); end
  endtask

  task automatic test_sign_ext();
    logic [31:0] rd, erd;
    logic er, eer;
    int lat;
    logic [31:0] wd;
    wd = {$urandom_range(255, 0) << 24 | $urandom_range(65535, 0) << 8} | 32'h80;
    wd[7:0] = 8'h80;
    do_req(1'b1, 2'b00, 1'b0, 5'd9, wd, rd, er, lat);
    ref_op(1'b1, 2'b00, 1'b0, 5'd9, wd, erd, eer);
    n_tests++; if (mem[9] !== 8'h80) begin n_fail++; $display("FAIL bst_mem9: got %h want 80", mem[9]); end
    do_req(1'b0, 2'b00, 1'b1, 5'd9, 32'h0, rd, er, lat);
    n_tests++; if (rd !== 32'hFFFFFF80 || er !== 1'b0) begin n_fail++; $display("FAIL bld_signed: got %h/%b want ffffff80/0", rd, er); end
    n_tests++; if (lat != 2) begin n_fail++; $display("FAIL bld_signed_latency: got %0d want 2", lat); end
    do_req(1'b0, 2'b00, 1'b0, 5'd9, 32'h0, rd, er, lat);
    n_tests++; if (rd !== 32'h00000080 || er !== 1'b0) begin n_fail++; $display("FAIL bld_unsigned: got %h/%b want 00000080/0", rd, er); end
    n_tests++; if (lat != 2) begin n_fail++; $display("FAIL bld_unsigned_latency: got %0d want 2", lat); end
  endtask

  task automatic test_top_half();
    logic [31:0] rd, erd;
    logic er, eer;
    int lat;
    do_req(1'b1, 2'b01, 1'b0, 5'd30, 32'h1234ABCD, rd, er, lat);
    ref_op(1'b1, 2'b01, 1'b0, 5'd30, 32'h1234ABCD, erd, eer);
    n_tests++; if (lat != 3) begin n_fail++; $display("FAIL hst_latency: got %0d want 3", lat); end
    n_tests++;
    if (we_a.size() != 2) begin n_fail++; $display("FAIL hst_we_cycles: got %0d want 2", we_a.size()); end
    else if (we_a[0] !== 5'd30 || we_a[1] !== 5'd31 || we_d[0] !== 8'hCD || we_d[1] !== 8'hAB) begin
      n_fail++; $display("FAIL hst_bytes: got %0d:%h %0d:%h want 30:cd 31:ab", we_a[0], we_d[0], we_a[1], we_d[1]);
    end
    n_tests++; if (mem[30] !== 8'hCD || mem[31] !== 8'hAB) begin n_fail++; $display("FAIL hst_mem: got %h %h want cd ab", mem[30], mem[31]); end
    do_req(1'b0, 2'b01, 1'b1, 5'd30, 32'h0, rd, er, lat);
    n_tests++; if (rd !== 32'hFFFFABCD || er !== 1'b0) begin n_fail++; $display("FAIL hld_signed: got %h/%b want ffffabcd/0", rd, er); end
  endtask

  task automatic test_errors();
    logic [31:0] rd, erd;
    logic er, eer;
    int lat;
    int bad;
    logic       ew [3];
    logic [1:0] es [3];
    logic [4:0] ea [3];
    ew = '{1'b1, 1'b0, 1'b1};
    es = '{2'b10, 2'b01, 2'b11};
    ea = '{5'd5, 5'd3, 5'd0};
    for (int k = 0; k < 3; k++) begin
      do_req(ew[k], es[k], 1'b1, ea[k], $urandom, rd, er, lat);
      ref_op(ew[k], es[k], 1'b1, ea[k], 32'h0, erd, eer);
      n_tests++; if (er !== 1'b1 || rd !== 32'h0) begin n_fail++; $display("FAIL err%0d_resp: got %b/%h want 1/0", k, er, rd); end
      n_tests++; if (lat != 1) begin n_fail++; $display("FAIL err%0d_latency: got %0d want 1", k, lat); end
      n_tests++; if (we_a.size() != 0) begin n_fail++; $display("FAIL err%0d_we: got %0d writes want 0", k, we_a.size()); end
    end
    bad = 0;
    for (int i = 0; i < 32; i++) if (mem[i] !== ref_mem[i]) bad++;
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL err_mem: got %0d bytes differing want 0", bad); end
  endtask

  task automatic test_reset_mid_store();
    logic [7:0] old2, old3;
    int seen;
    old2 = mem[2];
    old3 = mem[3];
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_size = 2'b10;
    bus.req_signed = 1'b0; bus.req_addr = 5'd0; bus.req_wdata = 32'h11223344;
    n_tests++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL rms_ready: got %b want 1", bus.req_ready); end
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_tests++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL rms_we_gate: got %b want 0", mem_we); end
    @(negedge clk);
    reset = 1'b0;
    n_tests++; if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin
      n_fail++; $display("FAIL rms_after: got ready %b resp %b want 1 0", bus.req_ready, bus.resp_valid);
    end
    seen = 0;
    repeat (4) begin @(negedge clk); if (bus.resp_valid) seen++; end
    n_tests++; if (seen != 0) begin n_fail++; $display("FAIL rms_no_resp: got %0d pulses want 0", seen); end
    n_tests++; if (mem[0] !== 8'h44 || mem[1] !== 8'h33) begin n_fail++; $display("FAIL rms_low: got %h %h want 44 33", mem[0], mem[1]); end
    n_tests++; if (mem[2] !== old2 || mem[3] !== old3) begin
      n_fail++; $display("FAIL rms_high: got %h %h want %h %h", mem[2], mem[3], old2, old3);
    end
    ref_mem[0] = 8'h44;
    ref_mem[1] = 8'h33;
  endtask

  task automatic test_random();
    logic [31:0] rd, erd, wd;
    logic er, eer, w, sg;
    logic [1:0] sz;
    logic [4:0] a;
    int lat, exp_lat, exp_we, bad;
    for (int k = 0; k < 40; k++) begin
      w  = 1'($urandom % 2);
      sz = 2'($urandom % 4);
      sg = 1'($urandom % 2);
      a  = 5'($urandom % 32);
      wd = $urandom;
      if (($urandom % 4) != 0 && sz != 2'b11) a = 5'((int'(a) >> sz) << sz);
      do_req(w, sz, sg, a, wd, rd, er, lat);
      ref_op(w, sz, sg, a, wd, erd, eer);
      exp_lat = eer ? 1 : (1 << sz) + 1;
      exp_we  = (w && !eer) ? (1 << sz) : 0;
      n_tests++;
      if (rd !== erd || er !== eer || lat != exp_lat || we_a.size() != exp_we) begin
        n_fail++;
        $display("FAIL rnd%0d w%0d sz%0d a%0d: got %h/%b lat%0d we%0d want %h/%b lat%0d we%0d",
                 k, w, sz, a, rd, er, lat, we_a.size(), erd, eer, exp_lat, exp_we);
      end
    end
    bad = 0;
    for (int i = 0; i < 32; i++) if (mem[i] !== ref_mem[i]) bad++;
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL rnd_mem: got %0d bytes differing want 0", bad); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] erd;
    logic eer, w, sg;
    logic [4:0] a;
    logic [31:0] wd;
    int bad;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      w  = 1'(k % 2);
      sg = 1'($urandom % 2);
      a  = 5'($urandom % 32);
      wd = $urandom;
      bus.req_valid = 1'b1; bus.req_write = w; bus.req_size = 2'b00;
      bus.req_signed = sg; bus.req_addr = a; bus.req_wdata = wd;
      n_tests++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL b2b%0d_accept: got ready %b want 1", k, bus.req_ready); end
      ref_op(w, 2'b00, sg, a, wd, erd, eer);
      @(negedge clk);
      n_tests++; if (bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL b2b%0d_busy1: got ready %b want 0", k, bus.req_ready); end
      bus.req_write = 1'($urandom % 2); bus.req_size = 2'($urandom % 4);
      bus.req_addr = 5'($urandom % 32); bus.req_wdata = $urandom;
      @(negedge clk);
      n_tests++;
      if (bus.req_ready !== 1'b0 || bus.resp_valid !== 1'b1 || bus.resp_rdata !== erd || bus.resp_error !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b%0d_resp: got ready %b valid %b data %h err %b want 0 1 %h 0",
                 k, bus.req_ready, bus.resp_valid, bus.resp_rdata, bus.resp_error, erd);
      end
    end
    bus.req_valid = 1'b0;
    @(negedge clk);
    bad = 0;
    for (int i = 0; i < 32; i++) if (mem[i] !== ref_mem[i]) bad++;
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL b2b_mem: got %0d bytes differing want 0", bad); end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b1;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'b00;
    bus.req_signed = 1'b0; bus.req_addr = 5'd0; bus.req_wdata = 32'h0;
    for (int i = 0; i < 32; i++) begin
      ref_mem[i] = 8'($urandom);
      mem[i] <= ref_mem[i];
    end
    test_reset();
    test_word_store_load();
    test_sign_ext();
    test_top_half();
    test_errors();
    test_reset_mid_store();
    test_random();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
